// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU between NUM_REQ requesters; registered response with flags and id.
// Optional ALU_ARB_STATS_EN adds saturating stat_ops / stat_stall counters.

module ALU (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [2:0] ALU_control,
  input  logic [3:0] samt,
  output logic [7:0] RESULT,
  output logic       OVERFLOW,
  output logic       NEGATIVE,
  output logic       ZERO,
  output logic       CARRY
);
  logic [7:0] bb;
  logic [7:0] sum;
  logic       c_out;

  // op[0] selects subtract (A + ~B + 1); the adder runs for every op
  always_comb begin
    bb = ALU_control[0] ? ~B : B;
    {c_out, sum} = {1'b0, A} + {1'b0, bb} + {8'd0, ALU_control[0]};
    case (ALU_control)
      3'b000, 3'b001: RESULT = sum;
      3'b010:         RESULT = A & B;
      3'b011:         RESULT = A | B;
      3'b100, 3'b101: RESULT = samt[3] ? 8'h00 : (sum << samt[2:0]);
      default:        RESULT = samt[3] ? 8'h00 : (sum >> samt[2:0]);
    endcase
    NEGATIVE = RESULT[7];
    ZERO     = (RESULT == 8'h00);
    CARRY    = (ALU_control == 3'b010) ? 1'b0 : c_out;
    OVERFLOW = (ALU_control == 3'b010) ? 1'b0 : ((A[7] == bb[7]) && (sum[7] != A[7]));
  end
endmodule

module alu_req_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0] req_op,
  input  logic [4*NUM_REQ-1:0] req_samt,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_result,
  output logic [3:0]           rsp_flags,
  output logic [1:0]           dbg_state
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]          stat_ops,
  output logic [15:0]          stat_stall
`endif
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // req_ready is a one-hot pulse only in IDLE; rsp_* stay stable while rsp_valid && !rsp_ready.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t          state, state_d;
  logic [ID_W-1:0] last_grant, cap_id, grant_idx;
  logic [7:0]      cap_a, cap_b, alu_result;
  logic [2:0]      cap_op;
  logic [3:0]      cap_samt;
  logic            alu_ov, alu_neg, alu_zero, alu_carry;
  logic            grant_found;
  int              grant_int;
  int              cand;

  // Search starts just above the last winner and wraps modulo NUM_REQ
  always_comb begin
    grant_found = 1'b0;
    grant_int   = 0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_int   = cand;
      end
    end
    grant_idx = grant_int[ID_W-1:0];
  end

  always_comb begin
    state_d   = state;
    req_ready = '0;
    case (state)
      IDLE: if (grant_found) begin
        req_ready[grant_idx] = 1'b1;
        state_d              = EXEC;
      end
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid = (state == RESP);
  assign dbg_state = state;

  ALU u_alu (
    .A           (cap_a),
    .B           (cap_b),
    .ALU_control (cap_op),
    .samt        (cap_samt),
    .RESULT      (alu_result),
    .OVERFLOW    (alu_ov),
    .NEGATIVE    (alu_neg),
    .ZERO        (alu_zero),
    .CARRY       (alu_carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      cap_id     <= '0;
      cap_a      <= '0;
      cap_b      <= '0;
      cap_op     <= '0;
      cap_samt   <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && grant_found) begin
        cap_a      <= req_a[8*grant_int +: 8];
        cap_b      <= req_b[8*grant_int +: 8];
        cap_op     <= req_op[3*grant_int +: 3];
        cap_samt   <= req_samt[4*grant_int +: 4];
        cap_id     <= grant_idx;
        last_grant <= grant_idx;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_flags  <= {alu_ov, alu_neg, alu_zero, alu_carry};
        rsp_id     <= cap_id;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else if (state == RESP) begin
      if (rsp_ready && stat_ops != 16'hFFFF)    stat_ops   <= stat_ops + 16'd1;
      if (!rsp_ready && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif
endmodule
